// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage with a single-outstanding valid/ready
//               memory port, redirect handling and the IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                         DATA_WIDTH    = 32,
  parameter int                         ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  input  logic                     stall_f,
  input  logic                     stall_d,
  input  logic                     flush_d,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d,
  output logic                     fetch_busy
);

  localparam logic [DATA_WIDTH-1:0]    C_NOP   = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0] C_FOUR  = ADDRESS_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                   state_q,    state_d;
  logic [ADDRESS_WIDTH-1:0] pc_f_q,     pc_f_d;
  logic [ADDRESS_WIDTH-1:0] req_pc_q,   req_pc_d;
  logic                     drop_q,     drop_d;
  logic [DATA_WIDTH-1:0]    hold_q,     hold_d;
  logic [DATA_WIDTH-1:0]    instr_q,    instr_nxt;
  logic [ADDRESS_WIDTH-1:0] pc_id_q,    pc_id_d;
  logic [ADDRESS_WIDTH-1:0] pc4_id_q,   pc4_id_d;
  logic                     valid_id_q, valid_id_d;

  logic                     req_valid;
  logic                     consume;
  logic [DATA_WIDTH-1:0]    consume_data;
  logic [ADDRESS_WIDTH-1:0] req_pc_plus4;

  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    hold_d       = hold_q;
    consume      = 1'b0;
    consume_data = imem_rsp_data;
    req_pc_plus4 = req_pc_q + C_FOUR;
    req_valid    = (state_q == ST_REQ) && !rst && !stall_f && !pc_src_e;

    case (state_q)
      ST_REQ: begin
        if (req_valid && imem_req_ready) begin
          req_pc_d = pc_f_q;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A redirect with no response yet leaves the in-flight fetch to be dropped later.
        if (pc_src_e) begin
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else if (!stall_d) begin
            consume = 1'b1;
            pc_f_d  = req_pc_plus4;
            state_d = ST_REQ;
          end else begin
            hold_d  = imem_rsp_data;
            pc_f_d  = req_pc_plus4;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (pc_src_e) begin
          state_d = ST_REQ;
        end else if (!stall_d) begin
          consume      = 1'b1;
          consume_data = hold_q;
          state_d      = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (pc_src_e) begin
      pc_f_d = pc_target_e;
    end
  end

  // IF/ID: redirect/flush beat stall; an unstalled decode with nothing new gets a bubble.
  always_comb begin
    instr_nxt  = instr_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    valid_id_d = valid_id_q;
    if (pc_src_e || flush_d || (!stall_d && !consume)) begin
      instr_nxt  = C_NOP;
      pc_id_d    = '0;
      pc4_id_d   = '0;
      valid_id_d = 1'b0;
    end else if (consume) begin
      instr_nxt  = consume_data;
      pc_id_d    = req_pc_q;
      pc4_id_d   = req_pc_plus4;
      valid_id_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_f_q     <= RESET_PC;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      hold_q     <= '0;
      instr_q    <= C_NOP;
      pc_id_q    <= '0;
      pc4_id_q   <= '0;
      valid_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      hold_q     <= hold_d;
      instr_q    <= instr_nxt;
      pc_id_q    <= pc_id_d;
      pc4_id_q   <= pc4_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_addr      = pc_f_q;
  assign instr_d        = instr_q;
  assign pc_d           = pc_id_q;
  assign pc_plus4_d     = pc4_id_q;
  assign valid_d        = valid_id_q;
  assign fetch_busy     = (state_q != ST_REQ);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Cycle-vector bench for fetch_unit plus wrap-around and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src_e, stall_f, stall_d, flush_d, req_ready, rsp_valid;
  logic [31:0] target, rsp_data;
  logic        req_valid, valid_d, busy;
  logic [31:0] addr, instr_d, pc_d, pc4_d;

  logic        w_ready, w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_req_valid, w_valid_d, w_busy;
  logic [31:0] w_addr, w_instr_d, w_pc_d, w_pc4_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .pc_src_e(pc_src_e), .pc_target_e(target),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc4_d), .valid_d(valid_d),
    .fetch_busy(busy)
  );

  fetch_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .pc_src_e(1'b0), .pc_target_e(32'h0),
    .stall_f(1'b0), .stall_d(1'b0), .flush_d(1'b0),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_ready), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .instr_d(w_instr_d), .pc_d(w_pc_d), .pc_plus4_d(w_pc4_d), .valid_d(w_valid_d),
    .fetch_busy(w_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        src, sf, sd, fl, rdy, rv;
    logic [31:0] tgt, data;
    logic        e_rv, e_busy, e_vd;
    logic [31:0] e_addr, e_instr, e_pc, e_pc4;
  } vec_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  vec_t v [29];

  task automatic setv(input int i, input logic src, sf, sd, fl, rdy, rv,
                      input logic [31:0] tgt, data,
                      input logic e_rv, e_busy, e_vd,
                      input logic [31:0] e_addr, e_instr, e_pc, e_pc4);
    v[i] = '{src, sf, sd, fl, rdy, rv, tgt, data, e_rv, e_busy, e_vd, e_addr, e_instr, e_pc, e_pc4};
  endtask

  initial begin
    //        src sf sd fl rdy rv  target        data           rv bsy vd addr          instr         pc            pc4
    setv( 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,         1, 0, 0, 32'h0,        NOP,          32'h0,        32'h0);
    setv( 1, 0, 0, 0, 0, 1, 1, 32'h0,        32'h0050_0093, 0, 1, 0, 32'h0,        NOP,          32'h0,        32'h0);
    setv( 2, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,         1, 0, 1, 32'h4,        32'h0050_0093, 32'h0,       32'h4);
    setv( 3, 0, 0, 0, 0, 0, 1, 32'h0,        32'h00A0_0113, 0, 1, 0, 32'h4,        NOP,          32'h0,        32'h0);
    setv( 4, 0, 0, 1, 0, 1, 0, 32'h0,        32'h0,         1, 0, 1, 32'h8,        32'h00A0_0113, 32'h4,       32'h8);
    setv( 5, 0, 0, 1, 0, 0, 1, 32'h0,        32'h0030_8193, 0, 1, 1, 32'h8,        32'h00A0_0113, 32'h4,       32'h8);
    setv( 6, 0, 0, 1, 0, 1, 0, 32'h0,        32'h0,         0, 1, 1, 32'hC,        32'h00A0_0113, 32'h4,       32'h8);
    setv( 7, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,         0, 1, 1, 32'hC,        32'h00A0_0113, 32'h4,       32'h8);
    setv( 8, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,         1, 0, 1, 32'hC,        32'h0030_8193, 32'h8,       32'hC);
    setv( 9, 1, 0, 0, 0, 1, 0, 32'h100,      32'h0,         0, 1, 0, 32'hC,        NOP,          32'h0,        32'h0);
    setv(10, 0, 0, 0, 0, 1, 1, 32'h0,        32'hDEAD_BEEF, 0, 1, 0, 32'h100,      NOP,          32'h0,        32'h0);
    setv(11, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,         1, 0, 0, 32'h100,      NOP,          32'h0,        32'h0);
    setv(12, 1, 0, 0, 0, 1, 1, 32'h200,      32'h1234_5678, 0, 1, 0, 32'h100,      NOP,          32'h0,        32'h0);
    setv(13, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,         1, 0, 0, 32'h200,      NOP,          32'h0,        32'h0);
    setv(14, 0, 0, 0, 0, 1, 1, 32'h0,        32'h0000_0513, 0, 1, 0, 32'h200,      NOP,          32'h0,        32'h0);
    setv(15, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1, 0, 1, 32'h204,      32'h0000_0513, 32'h200,     32'h204);
    for (int i = 16; i < 20; i++)
      setv(i, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,         1, 0, 0, 32'h204,      NOP,          32'h0,        32'h0);
    setv(20, 0, 1, 0, 0, 1, 0, 32'h0,        32'h0,         0, 0, 0, 32'h204,      NOP,          32'h0,        32'h0);
    setv(21, 0, 1, 0, 0, 1, 0, 32'h0,        32'h0,         0, 0, 0, 32'h204,      NOP,          32'h0,        32'h0);
    setv(22, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,         1, 0, 0, 32'h204,      NOP,          32'h0,        32'h0);
    setv(23, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0010_0073, 0, 1, 0, 32'h204,      NOP,          32'h0,        32'h0);
    setv(24, 0, 0, 1, 1, 0, 0, 32'h0,        32'h0,         1, 0, 1, 32'h208,      32'h0010_0073, 32'h204,     32'h208);
    setv(25, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,         1, 0, 0, 32'h208,      NOP,          32'h0,        32'h0);
    setv(26, 0, 0, 1, 0, 0, 1, 32'h0,        32'hAAAA_5555, 0, 1, 0, 32'h208,      NOP,          32'h0,        32'h0);
    setv(27, 1, 0, 1, 0, 0, 0, 32'h300,      32'h0,         0, 1, 0, 32'h20C,      NOP,          32'h0,        32'h0);
    setv(28, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1, 0, 0, 32'h300,      NOP,          32'h0,        32'h0);

    rst = 1'b1;
    {pc_src_e, stall_f, stall_d, flush_d, rsp_valid} = '0;
    req_ready = 1'b1;
    target = '0;
    rsp_data = '0;
    w_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_instr_d", instr_d, NOP);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_pc4_d", pc4_d, 32'h0);
    chk("rst_valid_d", {31'b0, valid_d}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      if (i > 0) @(negedge clk);
      pc_src_e  = v[i].src;
      stall_f   = v[i].sf;
      stall_d   = v[i].sd;
      flush_d   = v[i].fl;
      req_ready = v[i].rdy;
      rsp_valid = v[i].rv;
      target    = v[i].tgt;
      rsp_data  = v[i].data;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'b0, req_valid}, {31'b0, v[i].e_rv});
      chk($sformatf("v%0d_busy", i),      {31'b0, busy},      {31'b0, v[i].e_busy});
      chk($sformatf("v%0d_valid_d", i),   {31'b0, valid_d},   {31'b0, v[i].e_vd});
      chk($sformatf("v%0d_addr", i),      addr,    v[i].e_addr);
      chk($sformatf("v%0d_instr_d", i),   instr_d, v[i].e_instr);
      chk($sformatf("v%0d_pc_d", i),      pc_d,    v[i].e_pc);
      chk($sformatf("v%0d_pc4_d", i),     pc4_d,   v[i].e_pc4);
    end

    // Issue a request to 0x300, then reset asynchronously while it is outstanding.
    @(negedge clk);
    {pc_src_e, stall_f, stall_d, flush_d, rsp_valid} = '0;
    req_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("midreq_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'h0);
    chk("async_rst_addr", addr, 32'h0);
    chk("async_rst_req_valid", {31'b0, req_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_valid", {31'b0, req_valid}, 32'h1);
    chk("post_rst_addr", addr, 32'h0);

    // Wrap-around fetch at the top of the address space.
    req_ready = 1'b0;
    w_ready = 1'b1;
    #1;
    chk("wrap_req_valid", {31'b0, w_req_valid}, 32'h1);
    chk("wrap_req_addr", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_ready = 1'b0;
    w_rsp_valid = 1'b1;
    w_rsp_data = 32'h00C0_0193;
    #1;
    chk("wrap_busy", {31'b0, w_busy}, 32'h1);
    @(negedge clk);
    w_rsp_valid = 1'b0;
    #1;
    chk("wrap_instr_d", w_instr_d, 32'h00C0_0193);
    chk("wrap_pc_d", w_pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc4_d", w_pc4_d, 32'h0);
    chk("wrap_valid_d", {31'b0, w_valid_d}, 32'h1);
    chk("wrap_next_addr", w_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
